// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   - arb_state_t     : arbiter FSM states (IDLE, ACCESS, RESP)
//   - SZ_*            : memory access_size codes
//   - OWNER_*         : which requester owns the in-flight access
//   - DEF_MEM_*       : default memory window placement
//   - zero_extend()   : trims right-aligned memory data to the access size
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  localparam logic [31:0] DEF_MEM_OFFSET = 32'h8002_0000;
  localparam logic [31:0] DEF_MEM_SIZE   = 32'h0010_0000;

  // Memory returns data right-aligned; bits above the access size are don't-care.
  function automatic logic [31:0] zero_extend(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] result;
    case (size)
      SZ_BYTE: result = {24'h00_0000, data[7:0]};
      SZ_HALF: result = {16'h0000, data[15:0]};
      SZ_WORD: result = data;
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for one memory request.
// Parameters: MEM_OFFSET / MEM_SIZE place the legal byte window.
// Ports:
//   addr  in  32  request byte address
//   size  in  2   access size code (SZ_BYTE / SZ_HALF / SZ_WORD, 11 illegal)
//   err   out 1   request must not reach memory
module mem_access_check
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_OFFSET = DEF_MEM_OFFSET,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err
);

  logic [31:0] rel_addr_s;
  logic        in_range_s;
  logic        bad_size_s;
  logic        misaligned_s;

  // Classify the request: window membership, size code and natural alignment.
  always_comb begin
    // Offset from window base; only meaningful when addr >= MEM_OFFSET, which
    // is checked alongside so the subtraction never wraps into a false hit.
    rel_addr_s   = addr - MEM_OFFSET;
    in_range_s   = (addr >= MEM_OFFSET) && (rel_addr_s < MEM_SIZE);
    bad_size_s   = 1'b0;
    misaligned_s = 1'b0;
    case (size)
      SZ_BYTE: misaligned_s = 1'b0;
      SZ_HALF: misaligned_s = addr[0];
      SZ_WORD: misaligned_s = (addr[1:0] != 2'b00);
      default: bad_size_s   = 1'b1;
    endcase
    err = !in_range_s || bad_size_s || misaligned_s;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory port between instruction fetch and the
// load/store stage. Grants one requester per access, rejects out-of-window,
// misaligned or illegal-size requests without touching memory, drives the
// memory for one ACCESS cycle and returns data with a one-cycle rvalid pulse.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- ties go to the requester
// not granted last (otherwise data always beats fetch).
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_req/if_addr                   fetch request (word read)
//   if_gnt/if_rvalid/if_rdata/if_err fetch grant and completion
//   d_req/d_addr/d_wdata/d_write/d_size  load/store request
//   d_gnt/d_rvalid/d_rdata/d_err     load/store grant and completion
//   mem_address/mem_data_in/mem_write/mem_access_size  to memory
//   mem_data_out                     from memory, valid in RESP
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_OFFSET = DEF_MEM_OFFSET,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_out
);

  arb_state_t  state_r;
  arb_state_t  state_nxt_s;

  // Latched request attributes that outlive the grant cycle.
  logic        owner_r;
  logic        req_write_r;
  logic [1:0]  req_size_r;
  logic        req_err_r;

  logic [31:0] mem_address_r;
  logic [31:0] mem_data_in_r;
  logic [1:0]  mem_access_size_r;

  logic        grant_window_s;
  logic        pick_d_s;
  logic        gnt_any_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_write_s;
  logic [1:0]  sel_size_s;
  logic        chk_err_s;
  logic        resp_s;
  logic [31:0] load_data_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_owner_r;
`endif

  // Arbitration and selection of the request that would be latched this edge.
  always_comb begin
    grant_window_s = ((state_r == IDLE) || (state_r == RESP)) && !reset;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (d_req && if_req) begin
      pick_d_s = (last_owner_r == OWNER_IF);
    end else begin
      pick_d_s = d_req;
    end
`else
    pick_d_s = d_req;
`endif
    d_gnt     = grant_window_s && d_req && pick_d_s;
    if_gnt    = grant_window_s && if_req && !pick_d_s;
    gnt_any_s = d_gnt || if_gnt;
    if (pick_d_s) begin
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
      sel_write_s = d_write;
      sel_size_s  = d_size;
    end else begin
      sel_addr_s  = if_addr;
      sel_wdata_s = 32'h0000_0000;
      sel_write_s = 1'b0;
      sel_size_s  = SZ_WORD;
    end
  end

  // The check looks at exactly what is about to be latched, so the grant
  // edge already knows whether to skip the ACCESS cycle.
  mem_access_check #(
    .MEM_OFFSET (MEM_OFFSET),
    .MEM_SIZE   (MEM_SIZE)
  ) u_check (
    .addr (sel_addr_s),
    .size (sel_size_s),
    .err  (chk_err_s)
  );

  // Next-state logic: faulting grants bypass ACCESS and answer immediately.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, RESP: begin
        if (gnt_any_s) begin
          state_nxt_s = chk_err_s ? RESP : ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus request latch; memory-side registers only change on
  // legal grants so they hold their last values across faults and idle time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      owner_r           <= OWNER_D;
      req_write_r       <= 1'b0;
      req_size_r        <= SZ_WORD;
      req_err_r         <= 1'b0;
      mem_address_r     <= MEM_OFFSET;
      mem_data_in_r     <= 32'h0000_0000;
      mem_access_size_r <= SZ_WORD;
    end else begin
      state_r <= state_nxt_s;
      if (gnt_any_s) begin
        owner_r     <= d_gnt ? OWNER_D : OWNER_IF;
        req_write_r <= sel_write_s;
        req_size_r  <= sel_size_s;
        req_err_r   <= chk_err_s;
        if (!chk_err_s) begin
          mem_address_r     <= sel_addr_s;
          mem_data_in_r     <= sel_wdata_s;
          mem_access_size_r <= sel_size_s;
        end
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remembers the last winner so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_r <= OWNER_D;
    end else if (gnt_any_s) begin
      last_owner_r <= d_gnt ? OWNER_D : OWNER_IF;
    end
  end
`endif

  // Memory strobe and response decode. mem_write is gated by reset directly
  // so a reset arriving during ACCESS stops the store before its negedge.
  // Read data is combinational because memory only presents it during RESP.
  always_comb begin
    resp_s      = (state_r == RESP);
    mem_write   = (state_r == ACCESS) && req_write_r && !reset;
    if (req_err_r || req_write_r) begin
      load_data_s = 32'h0000_0000;
    end else begin
      load_data_s = zero_extend(mem_data_out, req_size_r);
    end
    d_rvalid  = resp_s && (owner_r == OWNER_D);
    if_rvalid = resp_s && (owner_r == OWNER_IF);
    d_err     = d_rvalid && req_err_r;
    if_err    = if_rvalid && req_err_r;
    d_rdata   = d_rvalid ? load_data_s : 32'h0000_0000;
    if_rdata  = if_rvalid ? load_data_s : 32'h0000_0000;
  end

  assign mem_address     = mem_address_r;
  assign mem_data_in     = mem_data_in_r;
  assign mem_access_size = mem_access_size_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] OFF = 32'h8002_0000;
  localparam logic [31:0] SZ  = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_write, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write;
  logic [1:0]  mem_access_size;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic last_was_d = 1'b1;

  // Memory model: small byte array, big-endian, right-aligned data bus.
  logic [7:0]  mem_arr [0:255];
  logic        tb_clear = 1'b0;
  logic        tb_pre_we = 1'b0;
  logic [31:0] tb_pre_addr = 32'h0;
  logic [31:0] tb_pre_data = 32'h0;

  // Reference model: sparse byte map keyed by full address.
  logic [7:0]  ref_arr [logic [31:0]];

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_access_size(mem_access_size), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory store path on negedge (plus bench-side preload / clear).
  always @(negedge clk) begin
    if (tb_clear) begin
      for (int k = 0; k < 256; k++) mem_arr[k] <= 8'h00;
    end else if (tb_pre_we) begin
      mem_arr[tb_pre_addr[7:0]]         <= tb_pre_data[31:24];
      mem_arr[tb_pre_addr[7:0] + 8'd1]  <= tb_pre_data[23:16];
      mem_arr[tb_pre_addr[7:0] + 8'd2]  <= tb_pre_data[15:8];
      mem_arr[tb_pre_addr[7:0] + 8'd3]  <= tb_pre_data[7:0];
    end else if (mem_write === 1'b1) begin
      wr_count <= wr_count + 1;
      case (mem_access_size)
        2'b00: mem_arr[mem_address[7:0]] <= mem_data_in[7:0];
        2'b01: begin
          mem_arr[mem_address[7:0]]        <= mem_data_in[15:8];
          mem_arr[mem_address[7:0] + 8'd1] <= mem_data_in[7:0];
        end
        default: begin
          mem_arr[mem_address[7:0]]        <= mem_data_in[31:24];
          mem_arr[mem_address[7:0] + 8'd1] <= mem_data_in[23:16];
          mem_arr[mem_address[7:0] + 8'd2] <= mem_data_in[15:8];
          mem_arr[mem_address[7:0] + 8'd3] <= mem_data_in[7:0];
        end
      endcase
    end
  end

  // Upper bits beyond the access size carry junk so trimming is exercised.
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] s);
    logic [7:0] i;
    i = a[7:0];
    case (s)
      2'b00:   return {24'hC3C3C3, mem_arr[i]};
      2'b01:   return {16'hC3C3, mem_arr[i], mem_arr[i + 8'd1]};
      default: return {mem_arr[i], mem_arr[i + 8'd1], mem_arr[i + 8'd2], mem_arr[i + 8'd3]};
    endcase
  endfunction

  // Memory read path: captured on posedge.
  always @(posedge clk) mem_data_out <= mem_rd(mem_address, mem_access_size);

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nbytes(s); k++) v = {v[23:0], ref_byte(a + 32'(k))};
    return v;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
    int n;
    n = nbytes(s);
    for (int k = 0; k < n; k++) ref_arr[a + 32'(k)] = 8'(wd >> (8 * (n - 1 - k)));
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [1:0] s);
    logic oor, mis;
    oor = (a < OFF) || (a > OFF + SZ - 32'd1);
    mis = ((s == 2'b10) && (a % 32'd4 != 32'd0)) || ((s == 2'b01) && (a % 32'd2 != 32'd0));
    return oor || mis || (s == 2'b11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_errs"}, 32'({if_err, d_err}), 32'd0);
    chk({tag, "_rdata"}, if_rdata | d_rdata, 32'd0);
    chk({tag, "_mem_address"}, mem_address, OFF);
    chk({tag, "_mem_data_in"}, mem_data_in, 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_size"}, 32'(mem_access_size), 32'd2);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    tb_pre_addr = a; tb_pre_data = w; tb_pre_we = 1'b1;
    @(negedge clk); #1; tb_pre_we = 1'b0;
    @(posedge clk); #1;
    ref_write(a, w, 2'b10);
  endtask

  task automatic clear_mem();
    tb_clear = 1'b1;
    @(negedge clk); #1; tb_clear = 1'b0;
    @(posedge clk); #1;
    ref_arr.delete();
  endtask

  // One complete transaction from IDLE; called at posedge+1.
  task automatic txn(input string tag, input logic fetch, input logic [31:0] a,
                     input logic [31:0] wd, input logic w, input logic [1:0] s);
    logic got, ee, rv_other, e;
    logic [31:0] exp_rd, rd;
    int gw, lat, wr0;
    ee     = exp_err(a, s);
    exp_rd = (ee || w) ? 32'h0 : ref_read(a, s);
    wr0    = wr_count;
    if (fetch) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      d_req = 1'b1; d_addr = a; d_wdata = wd; d_write = w; d_size = s;
    end
    got = 1'b0; gw = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = fetch ? if_gnt : d_gnt;
      gw  = i;
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk({tag, "_gnt"}, 32'(got), 32'd1);
    chk({tag, "_gnt_wait"}, 32'(gw), 32'd0);
    got = 1'b0; lat = 0; rd = 32'h0; e = 1'b0; rv_other = 1'b0;
    for (int i = 1; i <= 6 && !got; i++) begin
      @(negedge clk);
      if (fetch ? if_rvalid : d_rvalid) begin
        got = 1'b1; lat = i;
        rd = fetch ? if_rdata : d_rdata;
        e  = fetch ? if_err : d_err;
        rv_other = fetch ? d_rvalid : if_rvalid;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_rvalid"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), ee ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(e), 32'(ee));
    chk({tag, "_other_rvalid"}, 32'(rv_other), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(fetch ? if_rvalid : d_rvalid), 32'd0);
    chk({tag, "_writes"}, 32'(wr_count - wr0), (w && !ee) ? 32'd1 : 32'd0);
    if (w && !ee) ref_write(a, wd, s);
    last_was_d = !fetch;
  endtask

  initial begin
    logic first_d;
    logic [31:0] exp_d, exp_f, ra;
    logic [1:0] rs;
    int rv_seen, wr0;

    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_write = 1'b0; d_size = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Fetch only.
    clear_mem();
    preload(OFF, 32'hDEAD_BEEF);
    txn("fetch_word", 1'b1, OFF, 32'h0, 1'b0, 2'b10);

    // Byte store then word / half loads.
    clear_mem();
    txn("store_byte", 1'b0, OFF + 32'd3, 32'h1234_56A5, 1'b1, 2'b00);
    txn("load_word", 1'b0, OFF, 32'h0, 1'b0, 2'b10);
    txn("load_half", 1'b0, OFF + 32'd2, 32'h0, 1'b0, 2'b01);

    // Contention: both request in the same cycle.
    preload(OFF + 32'd4, 32'hCAFE_F00D);
    exp_d = ref_read(OFF, 2'b10);
    exp_f = ref_read(OFF + 32'd4, 2'b10);
    first_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_d = !last_was_d;
`endif
    d_req = 1'b1; d_addr = OFF; d_write = 1'b0; d_size = 2'b10;
    if_req = 1'b1; if_addr = OFF + 32'd4;
    @(negedge clk);
    chk("tie_d_gnt", 32'(d_gnt), 32'(first_d));
    chk("tie_if_gnt", 32'(if_gnt), 32'(!first_d));
    @(posedge clk); #1;
    if (first_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    chk("tie_access_gnt", 32'(d_gnt | if_gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie_first_rvalid", 32'(first_d ? d_rvalid : if_rvalid), 32'd1);
    chk("tie_first_rdata", first_d ? d_rdata : if_rdata, first_d ? exp_d : exp_f);
    chk("tie_second_gnt", 32'(first_d ? if_gnt : d_gnt), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("tie_second_early", 32'(first_d ? if_rvalid : d_rvalid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tie_second_rvalid", 32'(first_d ? if_rvalid : d_rvalid), 32'd1);
    chk("tie_second_rdata", first_d ? if_rdata : d_rdata, first_d ? exp_f : exp_d);
    @(posedge clk); #1;
    last_was_d = !first_d;

    // Faulting requests.
    txn("err_range", 1'b0, 32'h8012_0000, 32'h1111_1111, 1'b1, 2'b10);
    txn("err_misalign", 1'b0, OFF + 32'd2, 32'h2222_2222, 1'b1, 2'b10);
    txn("err_size", 1'b0, OFF, 32'h3333_3333, 1'b1, 2'b11);
    txn("edge_last", 1'b0, OFF + SZ - 32'd1, 32'h0, 1'b0, 2'b00);
    txn("edge_past", 1'b0, OFF + SZ, 32'h0, 1'b0, 2'b00);
    txn("edge_below", 1'b0, OFF - 32'd1, 32'h0, 1'b0, 2'b00);

    // Reset during a store's ACCESS cycle.
    txn("pre_reset_store", 1'b0, OFF + 32'd16, 32'h0000_0011, 1'b1, 2'b00);
    wr0 = wr_count;
    d_req = 1'b1; d_addr = OFF + 32'd16; d_wdata = 32'h0000_005A; d_write = 1'b1; d_size = 2'b00;
    @(negedge clk);
    chk("rst_mid_gnt", 32'(d_gnt), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_vals("rst_mid");
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d_rvalid || if_rvalid) rv_seen++;
      @(posedge clk); #1;
    end
    chk("rst_mid_rvalid", 32'(rv_seen), 32'd0);
    chk("rst_mid_writes", 32'(wr_count - wr0), 32'd0);
    last_was_d = 1'b1;
    txn("rst_mid_readback", 1'b0, OFF + 32'd16, 32'h0, 1'b0, 2'b00);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: ra = OFF - 32'd4;
          1: ra = OFF + SZ;
          2: ra = 32'h0000_0000;
          default: ra = 32'hFFFF_FFFC;
        endcase
      end else begin
        ra = OFF + 32'($urandom_range(0, 63));
      end
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        txn("rand_fetch", 1'b1, ra, 32'h0, 1'b0, 2'b10);
      end else begin
        txn("rand_data", 1'b0, ra, $urandom, 1'($urandom_range(0, 1)), rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressed unified memory port between the instruction-fetch stage and the load/store (MEM) stage of the pipelined processor.
- Arbitrates between the two requesters and checks address range and alignment before touching memory.
- Sequences each access into memory's timing: write on negedge, read captured on posedge.
- Returns zero-extended read data and a completion pulse to the winning requester.

Parameters:
MEM_OFFSET, 32'h80020000, base byte address of the memory window
MEM_SIZE, 32'h00100000, window size in bytes; legal addresses are MEM_OFFSET to MEM_OFFSET+MEM_SIZE-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request (always 32-bit read)
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch completion pulse
if_rdata  out  32  fetch data, valid with if_rvalid
if_err  out  1  fetch fault, valid with if_rvalid
d_req  in  1  data request
d_addr  in  32  data byte address
d_wdata  in  32  store data, right-aligned
d_write  in  1  1=store, 0=load
d_size  in  2  00=byte, 01=half, 10=word, 11=illegal
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data completion pulse
d_rdata  out  32  load data, zero-extended; 0 for stores
d_err  out  1  data fault, valid with d_rvalid
mem_address  out  32  to memory address
mem_data_in  out  32  to memory data_in
mem_write  out  1  to memory write
mem_access_size  out  2  to memory access_size
mem_data_out  in  32  from memory data_out

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset.
- FSM has three states: IDLE, ACCESS, RESP.
- Reset values:
  - State is IDLE.
  - mem_address = MEM_OFFSET, mem_data_in = 0, mem_access_size = 2'b10, mem_write = 0.
  - All gnt, rvalid and err outputs are 0; both rdata outputs are 0.
- Grant (combinational):
  - A grant can be issued only in IDLE or RESP.
  - Default priority is fixed: d_req beats if_req. At most one gnt is high per cycle.
  - Holding req high while gnt is low is legal; address, data and size must stay stable until gnt.
  - On the grant edge, the arbiter latches the requester's address, wdata, write and size, plus an owner bit. Fetch uses size 10 and write 0.
- Check (on the latched request):
  - Error if the address is outside the window.
  - Error if size is 11.
  - Error if misaligned: word needs addr[1:0]=0, half needs addr[0]=0.
- State transitions:
  - On grant with check passing: go to ACCESS.
  - On grant with error: go straight to RESP with err=1 and rdata=0. Memory is never written on an error.
  - ACCESS always goes to RESP next cycle.
  - RESP goes to ACCESS on a new grant, to RESP on a new erroring grant, otherwise to IDLE.
- ACCESS cycle:
  - mem_* are driven from the latched request.
  - mem_write = latched write AND NOT reset, so the store lands on that cycle's negedge.
  - A load is captured by memory on the posedge that ends ACCESS.
- RESP cycle:
  - The owner's rvalid is high for exactly one cycle.
  - Load data is mem_data_out zero-extended by size: byte [7:0], half [15:0], word [31:0].
  - Stores return rdata=0.
- Latency and throughput:
  - Grant at edge T gives rvalid during cycle T+1..T+2.
  - Maximum throughput is one access per 2 cycles; back-to-back grants are allowed in RESP.
- Outside ACCESS: mem_write=0 and mem_address/mem_access_size hold their last values.
- Reset mid-ACCESS:
  - The write is suppressed in that same cycle.
  - The FSM goes to IDLE and no rvalid is issued.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - A last_owner register (reset = data) decides ties: with both requesting in the same grant cycle, the requester not granted last wins.
  - Prevents fetch starvation under back-to-back loads/stores.
- When undefined: fixed data-over-fetch priority; last_owner is not implemented.

Decomposition:
- Package mem_arb_pkg holds:
  - FSM state encoding (IDLE/ACCESS/RESP).
  - Size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - OWNER_IF/OWNER_D.
  - Default MEM_OFFSET/MEM_SIZE constants.
- Sub-module mem_access_check: purely combinational range and alignment check, with inputs addr, size, MEM_OFFSET, MEM_SIZE and output err.

Test Plan:
- Fetch only: if_req at 32'h80020000, memory word 32'hDEADBEEF; expect if_gnt in cycle 0, if_rvalid in cycle 2, if_rdata=32'hDEADBEEF, if_err=0.
- Simultaneous requests:
  - Default build: d_req load and if_req in the same cycle; d_gnt first, if_gnt at the following RESP; rvalids 2 cycles apart.
  - With MEM_ARB_ROUND_ROBIN_EN, repeated contention alternates grants.
- Byte store then load:
  - Store byte 8'hA5 to 32'h80020003; mem_write high only in ACCESS.
  - Word load from 32'h80020000 returns [7:0]=8'hA5.
  - Half load from 32'h80020002 returns 32'h000000A5 in bits [15:0] (zero-extended).
- Errors, each giving d_err=1, d_rdata=0, mem_write never asserted, rvalid one cycle after grant:
  - d_addr=32'h80120000 (out of range).
  - Word at 32'h80020002 (misaligned).
  - d_size=11.
- Reset mid-ACCESS: assert reset during a store's ACCESS cycle; the target bytes remain unchanged, d_rvalid is never raised, and all outputs return to reset values.
